fpga_word_entry: RTL and testbench

Board-side input block for the FPGA test wrappers. It synchronizes and debounces the four raw active-low pushbuttons, then assembles a 32-bit operand from the switch bank over one or two button presses. It presents the committed word, with a one-cycle valid pulse, to whatever unit the wrapper drives (ALU port, register file write, memory poke). It is the entry-side counterpart of the seven-segment word display: `staged` is intended to feed the display directly.

---
 rtl/fpga_word_entry_if.sv | 25 ++
 rtl/fpga_word_entry.sv | 140 ++++++++++++++
 tb/tb_fpga_word_entry.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fpga_word_entry_if.sv
// Output bundle of the word-entry block: committed word, staging view, FSM state and error pulse.
// The entry block drives it through the master modport; consumers use slave.
interface fpga_word_entry_if;
   logic [31:0] word;
   logic        word_valid;
   logic [31:0] staged;
   logic [1:0]  state;
   logic        err;

   modport master (
      output word,
      output word_valid,
      output staged,
      output state,
      output err
   );

   modport slave (
      input word,
      input word_valid,
      input staged,
      input state,
      input err
   );
endinterface

// File: rtl/fpga_word_entry.sv
// Pushbutton synchronizer/debouncer plus a small FSM that builds a 32-bit word from the
// switch bank over one or two presses and commits it with a one-cycle valid pulse.
module fpga_word_entry #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic [17:0]          SW,
   input  logic [3:0]           KEY,
   fpga_word_entry_if.master    out_if
);

   localparam int unsigned CntW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle     = 2'b00,
      StHaveLo   = 2'b01,
      StHaveBoth = 2'b10
   } state_e;

   logic [3:0]      sync1_q, sync1_d;
   logic [3:0]      sync2_q, sync2_d;
   logic [3:0]      stable_q, stable_d;
   logic [3:0]      press_q, press_d;
   logic [CntW-1:0] cnt_q [4];
   logic [CntW-1:0] cnt_d [4];

   state_e      state_q, state_d;
   logic [15:0] lo_q, lo_d;
   logic [15:0] hi_q, hi_d;
   logic [31:0] word_q, word_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;
   logic [15:0] ext;

   logic unused_sw;
   assign unused_sw = SW[16];

   // Debounce: a press event is registered on the edge the stable level falls to 0.
   always_comb begin
      sync1_d = KEY;
      sync2_d = sync1_q;
      for (int k = 0; k < 4; k++) begin
         stable_d[k] = stable_q[k];
         press_d[k]  = 1'b0;
         cnt_d[k]    = '0;
         if (sync2_q[k] != stable_q[k]) begin
            if (cnt_q[k] == CntMax) begin
               stable_d[k] = sync2_q[k];
               press_d[k]  = ~sync2_q[k];
            end else begin
               cnt_d[k] = cnt_q[k] + 1'b1;
            end
         end
      end
   end

   // Priority: clear > commit > load lo > load hi; any losing event flags err.
   always_comb begin
      state_d = state_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      word_d  = word_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      ext     = {16{lo_q[15] & SW[17]}};
      if (press_q[3]) begin
         lo_d    = '0;
         hi_d    = '0;
         state_d = StIdle;
         err_d   = |press_q[2:0];
      end else if (press_q[2]) begin
         err_d = |press_q[1:0];
         unique case (state_q)
            StHaveLo: begin
               word_d  = {ext, lo_q};
               valid_d = 1'b1;
               lo_d    = '0;
               hi_d    = '0;
               state_d = StIdle;
            end
            StHaveBoth: begin
               word_d  = {hi_q, lo_q};
               valid_d = 1'b1;
               lo_d    = '0;
               hi_d    = '0;
               state_d = StIdle;
            end
            default: err_d = 1'b1;
         endcase
      end else if (press_q[0]) begin
         err_d = press_q[1];
         lo_d  = SW[15:0];
         if (state_q == StIdle) state_d = StHaveLo;
      end else if (press_q[1]) begin
         if (state_q == StIdle) begin
            err_d = 1'b1;
         end else begin
            hi_d    = SW[15:0];
            state_d = StHaveBoth;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         sync1_q  <= 4'hF;
         sync2_q  <= 4'hF;
         stable_q <= 4'hF;
         press_q  <= 4'h0;
         for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
         state_q  <= StIdle;
         lo_q     <= '0;
         hi_q     <= '0;
         word_q   <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         press_q  <= press_d;
         for (int k = 0; k < 4; k++) cnt_q[k] <= cnt_d[k];
         state_q  <= state_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         word_q   <= word_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   assign out_if.word       = word_q;
   assign out_if.word_valid = valid_q;
   assign out_if.staged     = {hi_q, lo_q};
   assign out_if.state      = state_q;
   assign out_if.err        = err_q;

endmodule

// File: tb/tb_fpga_word_entry.sv
// Directed bench for fpga_word_entry with DEBOUNCE_CYCLES=4: a press driven just after an edge
// acts on the 7th following edge; outputs are sampled 1 time unit after each rising edge.
module tb_fpga_word_entry;
   localparam int unsigned D = 4;

   logic        CLK;
   logic        nRST;
   logic [17:0] SW;
   logic [3:0]  KEY;
   int          checks;
   int          errors;

   fpga_word_entry_if u_if ();

   fpga_word_entry #(
      .DEBOUNCE_CYCLES (D)
   ) u_dut (
      .CLK    (CLK),
      .nRST   (nRST),
      .SW     (SW),
      .KEY    (KEY),
      .out_if (u_if)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Press a key and stop at the sample point just after the edge where the FSM acts.
   task automatic tap(input int k);
      KEY[k] = 1'b0;
      step(D + 3);
   endtask

   task automatic release_key(input int k);
      KEY[k] = 1'b1;
      step(D + 4);
   endtask

   task automatic test_reset();
      nRST = 1'b0;
      KEY  = 4'hF;
      for (int i = 0; i < 3; i++) begin
         SW = 18'($urandom);
         step(1);
         checks++;
         if ({u_if.word, u_if.word_valid, u_if.staged, u_if.state, u_if.err} !== 68'h0) begin
            errors++;
            $display("FAIL reset_outputs cycle %0d: word=%h valid=%b staged=%h state=%b err=%b, want all 0",
                     i, u_if.word, u_if.word_valid, u_if.staged, u_if.state, u_if.err);
         end
      end
      nRST = 1'b1;
      step(2);
   endtask

   task automatic test_lo_zext();
      SW = 18'h0_8001;
      KEY[0] = 1'b0;
      step(D + 2);
      checks++;
      if (u_if.state !== 2'b00) begin
         errors++; $display("FAIL zext_early_state got %b want 00", u_if.state);
      end
      step(1);
      checks++;
      if (u_if.state !== 2'b01 || u_if.staged !== 32'h0000_8001) begin
         errors++;
         $display("FAIL zext_have_lo state=%b staged=%h want 01 00008001", u_if.state, u_if.staged);
      end
      release_key(0);
      KEY[2] = 1'b0;
      step(D + 2);
      checks++;
      if (u_if.word_valid !== 1'b0) begin
         errors++; $display("FAIL zext_valid_early got %b want 0", u_if.word_valid);
      end
      step(1);
      checks++;
      if (u_if.word_valid !== 1'b1 || u_if.word !== 32'h0000_8001 || u_if.state !== 2'b00) begin
         errors++;
         $display("FAIL zext_commit valid=%b word=%h state=%b want 1 00008001 00",
                  u_if.word_valid, u_if.word, u_if.state);
      end
      step(1);
      checks++;
      if (u_if.word_valid !== 1'b0 || u_if.word !== 32'h0000_8001 || u_if.staged !== 32'h0) begin
         errors++;
         $display("FAIL zext_after valid=%b word=%h staged=%h want 0 00008001 0",
                  u_if.word_valid, u_if.word, u_if.staged);
      end
      release_key(2);
   endtask

   task automatic test_lo_sext();
      SW = 18'h2_8001;
      tap(0);
      release_key(0);
      tap(2);
      checks++;
      if (u_if.word_valid !== 1'b1 || u_if.word !== 32'hFFFF_8001) begin
         errors++;
         $display("FAIL sext_commit valid=%b word=%h want 1 ffff8001", u_if.word_valid, u_if.word);
      end
      release_key(2);
   endtask

   task automatic test_full_word();
      SW = 18'h0_BEEF;
      tap(0);
      release_key(0);
      SW = 18'h0_DEAD;
      tap(1);
      checks++;
      if (u_if.state !== 2'b10 || u_if.staged !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL full_both state=%b staged=%h want 10 deadbeef", u_if.state, u_if.staged);
      end
      release_key(1);
      SW = 18'h3_0000;
      tap(2);
      checks++;
      if (u_if.word !== 32'hDEAD_BEEF || u_if.word_valid !== 1'b1 || u_if.staged !== 32'h0) begin
         errors++;
         $display("FAIL full_commit word=%h valid=%b staged=%h want deadbeef 1 0",
                  u_if.word, u_if.word_valid, u_if.staged);
      end
      release_key(2);
   endtask

   task automatic test_bounce_err();
      logic seen_err;
      logic seen_valid;
      seen_err   = 1'b0;
      seen_valid = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (i % 3 == 0) KEY[2] = ~KEY[2];
         step(1);
         seen_err   |= u_if.err;
         seen_valid |= u_if.word_valid;
      end
      KEY[2] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step(1);
         seen_err   |= u_if.err;
         seen_valid |= u_if.word_valid;
      end
      checks++;
      if (seen_err !== 1'b0 || seen_valid !== 1'b0 || u_if.state !== 2'b00) begin
         errors++;
         $display("FAIL bounce err=%b valid=%b state=%b want 0 0 00", seen_err, seen_valid, u_if.state);
      end
      tap(1);
      checks++;
      if (u_if.err !== 1'b1 || u_if.state !== 2'b00) begin
         errors++; $display("FAIL idle_hi_err err=%b state=%b want 1 00", u_if.err, u_if.state);
      end
      step(1);
      checks++;
      if (u_if.err !== 1'b0) begin
         errors++; $display("FAIL idle_hi_err_pulse err=%b want 0", u_if.err);
      end
      release_key(1);
      SW = 18'h0_1234;
      tap(0);
      release_key(0);
      KEY[3] = 1'b0;
      tap(0);
      checks++;
      if (u_if.err !== 1'b1 || u_if.state !== 2'b00 || u_if.staged !== 32'h0 ||
          u_if.word_valid !== 1'b0 || u_if.word !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL clear_vs_lo err=%b state=%b staged=%h valid=%b word=%h want 1 00 0 0 deadbeef",
                  u_if.err, u_if.state, u_if.staged, u_if.word_valid, u_if.word);
      end
      KEY[3] = 1'b1;
      release_key(0);
   endtask

   task automatic test_held_key();
      SW = 18'h0_0001;
      tap(0);
      checks++;
      if (u_if.state !== 2'b01 || u_if.staged !== 32'h0000_0001) begin
         errors++;
         $display("FAIL held_first state=%b staged=%h want 01 00000001", u_if.state, u_if.staged);
      end
      SW = 18'h0_0002;
      step(50 - (D + 3));
      checks++;
      if (u_if.staged !== 32'h0000_0001) begin
         errors++; $display("FAIL held_no_repeat staged=%h want 00000001", u_if.staged);
      end
      release_key(0);
      SW = 18'h0_0003;
      tap(0);
      checks++;
      if (u_if.staged !== 32'h0000_0003 || u_if.state !== 2'b01) begin
         errors++;
         $display("FAIL held_repress staged=%h state=%b want 00000003 01", u_if.staged, u_if.state);
      end
   endtask

   // Entered with KEY[0] still held low from test_held_key.
   task automatic test_key_through_reset();
      SW   = 18'h0_5A5A;
      nRST = 1'b0;
      step(2);
      nRST = 1'b1;
      checks++;
      if (u_if.word !== 32'h0 || u_if.staged !== 32'h0 || u_if.state !== 2'b00) begin
         errors++;
         $display("FAIL midreset word=%h staged=%h state=%b want 0 0 00",
                  u_if.word, u_if.staged, u_if.state);
      end
      step(D + 2);
      checks++;
      if (u_if.state !== 2'b00) begin
         errors++; $display("FAIL held_reset_early state=%b want 00", u_if.state);
      end
      step(1);
      checks++;
      if (u_if.state !== 2'b01 || u_if.staged !== 32'h0000_5A5A) begin
         errors++;
         $display("FAIL held_reset_press state=%b staged=%h want 01 00005a5a", u_if.state, u_if.staged);
      end
      release_key(0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      nRST   = 1'b0;
      SW     = '0;
      KEY    = 4'hF;
      #1;
      test_reset();
      test_lo_zext();
      test_lo_sext();
      test_full_word();
      test_bounce_err();
      test_held_key();
      test_key_through_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
